vram_arbiter: RTL

//  Shares the single-port 128x64x2-bit video RAM between the display scan-out (hard real-time reads)
//  and the CPU draw/clear engine (read, write, atomic XOR-with-collision). Display normally wins;
//  a starvation timer guarantees CPU progress. Sits between cpu and the vram macro, replacing the
//  CPU's direct vram_hpos/vpos/pixeli/pixelo/we wiring. One access per clock.

---
 rtl/vram_pkg.sv | 20 ++
 rtl/vram_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/vram_pkg.sv
// Shared VRAM definitions: CPU op codes, arbiter FSM encoding and geometry.
// Used by the arbiter, the CPU draw engine and the video scan-out.
package vram_pkg;

    localparam int unsigned VRAM_AW = 13;
    localparam int unsigned PIX_W   = 2;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_XOR   = 2'd2,
        OP_RSVD  = 2'd3
    } cpu_op_e;

    typedef enum logic {
        ARB = 1'b0,
        XWB = 1'b1
    } arb_state_e;

endpackage

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display scan-out normally wins, a starvation counter
// guarantees CPU progress, and CPU XOR is done as read then write-back cycle.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned HPOS_W   = 7,
    parameter int unsigned VPOS_W   = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       disp_req,
    input  logic [HPOS_W-1:0]          disp_hpos,
    input  logic [VPOS_W-1:0]          disp_vpos,
    output logic                       disp_rvalid,
    output logic [PIX_W-1:0]           disp_pixel,
    output logic                       disp_miss,
    input  logic                       cpu_req,
    input  logic [1:0]                 cpu_op,
    input  logic [HPOS_W-1:0]          cpu_hpos,
    input  logic [VPOS_W-1:0]          cpu_vpos,
    input  logic [PIX_W-1:0]           cpu_wdata,
    output logic                       cpu_gnt,
    output logic                       cpu_rvalid,
    output logic [PIX_W-1:0]           cpu_rdata,
    output logic                       cpu_collide,
    output logic                       busy,
    output logic [HPOS_W+VPOS_W-1:0]   mem_addr,
    output logic                       mem_we,
    output logic [PIX_W-1:0]           mem_din,
    input  logic [PIX_W-1:0]           mem_dout
);

    localparam int unsigned AW = HPOS_W + VPOS_W;
    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

    arb_state_e        state_q, state_d;
    logic [3:0]        starve_q, starve_d;
    logic [AW-1:0]     xor_addr_q;
    logic [PIX_W-1:0]  xor_wdata_q;
    logic              disp_rd_q;
    logic              cpu_rd_q;
    logic [PIX_W-1:0]  pix_q;

    logic              disp_win;
    logic              cpu_win;
    cpu_op_e           op;

    assign op = cpu_op_e'(cpu_op);

    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        disp_win  = 1'b0;
        cpu_win   = 1'b0;
        cpu_gnt   = 1'b0;
        disp_miss = 1'b0;
        busy      = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_din   = '0;
        case (state_q)
            ARB: begin
                cpu_win   = cpu_req && (!disp_req || (starve_q >= MaxWait));
                disp_win  = disp_req && !cpu_win;
                cpu_gnt   = cpu_win;
                disp_miss = disp_req && cpu_win;
                if (disp_win) begin
                    mem_addr = {disp_vpos, disp_hpos};
                end else if (cpu_win) begin
                    mem_addr = {cpu_vpos, cpu_hpos};
                    if (op == OP_WRITE) begin
                        mem_we  = 1'b1;
                        mem_din = cpu_wdata;
                    end
                    if (op == OP_XOR) begin
                        state_d = XWB;
                    end
                end
                if (cpu_req && !cpu_win) begin
                    starve_d = (starve_q == 4'hf) ? starve_q : starve_q + 4'd1;
                end else begin
                    starve_d = '0;
                end
            end
            XWB: begin
                // CPU owns this cycle: write back the XOR of the old pixel just read.
                busy      = 1'b1;
                disp_miss = disp_req;
                mem_addr  = xor_addr_q;
                mem_we    = 1'b1;
                mem_din   = mem_dout ^ xor_wdata_q;
                state_d   = ARB;
                if (!cpu_req) begin
                    starve_d = '0;
                end
            end
            default: state_d = ARB;
        endcase
    end

    assign cpu_rvalid  = cpu_rd_q || busy;
    assign cpu_rdata   = cpu_rvalid ? mem_dout : '0;
    assign cpu_collide = busy && (mem_dout != '0) && (xor_wdata_q != '0);
    assign disp_rvalid = disp_rd_q;
    assign disp_pixel  = disp_rd_q ? mem_dout : pix_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB;
            starve_q    <= '0;
            xor_addr_q  <= '0;
            xor_wdata_q <= '0;
            disp_rd_q   <= 1'b0;
            cpu_rd_q    <= 1'b0;
            pix_q       <= '0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            disp_rd_q <= disp_win;
            cpu_rd_q  <= cpu_win && ((op == OP_READ) || (op == OP_RSVD));
            if (cpu_win && (op == OP_XOR)) begin
                xor_addr_q  <= {cpu_vpos, cpu_hpos};
                xor_wdata_q <= cpu_wdata;
            end
            if (disp_rd_q) begin
                pix_q <= mem_dout;
            end
        end
    end

endmodule
